// File: rtl/spike_pkt_pkg.sv
// Shared types and default sizes for the spike packetizer.
// Holds the scan FSM state enum and the outgoing packet bundle.
package spike_pkt_pkg;

    localparam int DEF_N_NEURONS = 10;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_PTR_W     = 5;
    localparam int DEF_MAX_CONN  = 30;

    typedef enum logic [1:0] {
        IDLE,
        FIND,
        EMIT
    } state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] origin;
        logic [DEF_ADDR_W-1:0] dest;
    } pkt_t;

endpackage

// File: rtl/spike_prio_enc.sv
// Lowest-set-bit encoder over the spike work vector.
// Ports: vec (in), idx (out, lowest set bit), any (out, vec nonzero).
module spike_prio_enc #(
    parameter int N     = 10,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        // Walk downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/spike_packetizer.sv
// Turns per-timestep spike vectors into {origin, dest} packets by walking a
// CSR connection table. Ports: CLK/RESETn, spike/spike_valid in,
// neuron_addresses/connection_pointer/downstream_connections table in,
// pkt_valid/pkt_ready/pkt_origin/pkt_dest handshake, busy/done/cfg_err status.
module spike_packetizer
    import spike_pkt_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PTR_W     = DEF_PTR_W,
    parameter int MAX_CONN  = DEF_MAX_CONN
) (
    input  logic                          CLK,
    input  logic                          RESETn,
    input  logic [N_NEURONS-1:0]          spike,
    input  logic                          spike_valid,
    input  logic [ADDR_W*N_NEURONS-1:0]   neuron_addresses,
    input  logic [PTR_W*(N_NEURONS+1)-1:0] connection_pointer,
    input  logic [ADDR_W*MAX_CONN-1:0]    downstream_connections,
    output logic                          pkt_valid,
    input  logic                          pkt_ready,
    output logic [ADDR_W-1:0]             pkt_origin,
    output logic [ADDR_W-1:0]             pkt_dest,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);

    localparam int IDX_W = $clog2(N_NEURONS + 1);

    // Unpacked views of the flat table buses.
    logic [PTR_W-1:0]  ptr_a  [N_NEURONS+1];
    logic [ADDR_W-1:0] addr_a [N_NEURONS];
    logic [ADDR_W-1:0] ent_a  [MAX_CONN];

    for (genvar g = 0; g <= N_NEURONS; g++) begin : g_ptr
        assign ptr_a[g] = connection_pointer[PTR_W*g +: PTR_W];
    end

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_addr
        assign addr_a[g] = neuron_addresses[ADDR_W*g +: ADDR_W];
    end

    for (genvar g = 0; g < MAX_CONN; g++) begin : g_ent
        assign ent_a[g] = downstream_connections[ADDR_W*g +: ADDR_W];
    end

    state_t                 state, state_n;
    logic [N_NEURONS-1:0]   work, work_n;
    logic [N_NEURONS-1:0]   pending, pending_n;
    logic [PTR_W-1:0]       idx, idx_n;
    logic [PTR_W-1:0]       end_idx, end_idx_n;
    pkt_t                   pkt_q, pkt_n;
    logic                   vld_q, vld_n;
    logic                   err_q, err_n;

    logic [IDX_W-1:0]       sel;
    logic [IDX_W-1:0]       sel_nx;
    logic                   any;
    logic [PTR_W-1:0]       lo;
    logic [PTR_W-1:0]       hi;
    logic [PTR_W-1:0]       idx_inc;
    logic [N_NEURONS-1:0]   sp;
    logic                   xfer;

    spike_prio_enc #(
        .N     (N_NEURONS),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec (work),
        .idx (sel),
        .any (any)
    );

    assign sel_nx  = sel + 1'b1;
    assign lo      = ptr_a[sel];
    assign hi      = ptr_a[sel_nx];
    assign idx_inc = idx + 1'b1;
    assign sp      = spike_valid ? spike : '0;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= IDLE;
            work    <= '0;
            pending <= '0;
            idx     <= '0;
            end_idx <= '0;
            pkt_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            work    <= work_n;
            pending <= pending_n;
            idx     <= idx_n;
            end_idx <= end_idx_n;
            pkt_q   <= pkt_n;
            vld_q   <= vld_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        work_n    = work;
        pending_n = pending;
        idx_n     = idx;
        end_idx_n = end_idx;
        pkt_n     = pkt_q;
        vld_n     = vld_q;
        err_n     = err_q;
        done      = 1'b0;
        xfer      = 1'b0;

        unique case (state)
            IDLE: begin
                // A leftover pending vector starts a scan just like a strobe.
                if (spike_valid || (pending != '0)) begin
                    work_n    = sp | pending;
                    pending_n = '0;
                    state_n   = FIND;
                end
            end
            FIND: begin
                if (any) begin
                    work_n[sel]  = 1'b0;
                    idx_n        = lo;
                    end_idx_n    = hi;
                    pkt_n.origin = addr_a[sel];
                    if ((hi > lo) && (int'(hi) <= MAX_CONN)) begin
                        pkt_n.dest = ent_a[lo];
                        vld_n      = 1'b1;
                        state_n    = EMIT;
                    end else if ((hi < lo) || (int'(hi) > MAX_CONN)) begin
                        err_n = 1'b1;
                    end
                end else begin
                    done = 1'b1;
                    if (pending != '0) begin
                        work_n = pending;
                        xfer   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            EMIT: begin
                if (pkt_ready) begin
                    if (idx_inc == end_idx) begin
                        vld_n   = 1'b0;
                        state_n = FIND;
                    end else begin
                        idx_n      = idx_inc;
                        pkt_n.dest = ent_a[idx_inc];
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Strobes during a scan merge into pending; a strobe on the
        // pending->work transfer cycle lands in the freshly cleared pending.
        if (state != IDLE) begin
            pending_n = (xfer ? '0 : pending) | sp;
        end
    end

    assign pkt_valid  = vld_q;
    assign pkt_origin = pkt_q.origin;
    assign pkt_dest   = pkt_q.dest;
    assign busy       = (state != IDLE);
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_spike_packetizer.sv
// Directed bench for spike_packetizer with hand-computed packet lists.
// Uses the CSR table ptr={0,3,5,8,10,12,14,15,17,18,19}, address i = i.
module tb_spike_packetizer;

    localparam int NN = 10;
    localparam int AW = 12;
    localparam int PW = 5;
    localparam int MC = 30;

    logic                 CLK;
    logic                 RESETn;
    logic [NN-1:0]        spike;
    logic                 spike_valid;
    logic [AW*NN-1:0]     neuron_addresses;
    logic [PW*(NN+1)-1:0] connection_pointer;
    logic [AW*MC-1:0]     downstream_connections;
    logic                 pkt_valid;
    logic                 pkt_ready;
    logic [AW-1:0]        pkt_origin;
    logic [AW-1:0]        pkt_dest;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;

    logic [PW-1:0] ptr_t [NN+1];
    logic [AW-1:0] ent_t [MC];

    int n_vec;
    int n_err;

    int got_o [$];
    int got_d [$];
    int got_c [$];
    int exp_o [$];
    int exp_d [$];
    int n_done;

    spike_packetizer dut (
        .CLK                    (CLK),
        .RESETn                 (RESETn),
        .spike                  (spike),
        .spike_valid            (spike_valid),
        .neuron_addresses       (neuron_addresses),
        .connection_pointer     (connection_pointer),
        .downstream_connections (downstream_connections),
        .pkt_valid              (pkt_valid),
        .pkt_ready              (pkt_ready),
        .pkt_origin             (pkt_origin),
        .pkt_dest               (pkt_dest),
        .busy                   (busy),
        .done                   (done),
        .cfg_err                (cfg_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always_comb begin
        neuron_addresses       = '0;
        connection_pointer     = '0;
        downstream_connections = '0;
        for (int i = 0; i < NN; i++) begin
            neuron_addresses[AW*i +: AW] = AW'(i);
        end
        for (int i = 0; i <= NN; i++) begin
            connection_pointer[PW*i +: PW] = ptr_t[i];
        end
        for (int i = 0; i < MC; i++) begin
            downstream_connections[AW*i +: AW] = ent_t[i];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load_table();
        int p [11] = '{0, 3, 5, 8, 10, 12, 14, 15, 17, 18, 19};
        int e [10] = '{3, 5, 7, 4, 6, 4, 5, 6, 8, 9};
        for (int i = 0; i <= NN; i++) ptr_t[i] = PW'(p[i]);
        for (int i = 0; i < MC; i++) ent_t[i] = '0;
        for (int i = 0; i < 10; i++) ent_t[i] = AW'(e[i]);
    endtask

    task automatic fire(input logic [NN-1:0] v);
        spike       = v;
        spike_valid = 1'b1;
        tick();
        spike_valid = 1'b0;
        spike       = '0;
    endtask

    task automatic clear_lists();
        got_o.delete();
        got_d.delete();
        got_c.delete();
        exp_o.delete();
        exp_d.delete();
        n_done = 0;
    endtask

    task automatic expect_pkt(input int o, input int d);
        exp_o.push_back(o);
        exp_d.push_back(d);
    endtask

    // Records every handshake until the scan goes idle or the budget expires.
    task automatic collect(input string tag, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (pkt_valid && pkt_ready) begin
                got_o.push_back(int'(pkt_origin));
                got_d.push_back(int'(pkt_dest));
                got_c.push_back(c);
            end
            if (done) n_done++;
            if (!busy) break;
            tick();
        end
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_pkts(input string tag);
        int n;
        chk({tag, "_count"}, got_o.size(), exp_o.size());
        n = (got_o.size() < exp_o.size()) ? got_o.size() : exp_o.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_o%0d", tag, i), got_o[i], exp_o[i]);
            chk($sformatf("%s_d%0d", tag, i), got_d[i], exp_d[i]);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        RESETn      = 1'b0;
        spike       = '0;
        spike_valid = 1'b0;
        pkt_ready   = 1'b0;
        load_table();
        #12;
        chk("rst_valid", {31'b0, pkt_valid}, 0);
        chk("rst_origin", {20'b0, pkt_origin}, 0);
        chk("rst_dest", {20'b0, pkt_dest}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, cfg_err}, 0);
        tick();
        RESETn = 1'b1;
        tick();

        // 1: single neuron, cycle-exact
        pkt_ready = 1'b1;
        fire(10'b0000000001);
        chk("t1_find_busy", {31'b0, busy}, 1);
        chk("t1_find_vld", {31'b0, pkt_valid}, 0);
        tick();
        chk("t1_p0_vld", {31'b0, pkt_valid}, 1);
        chk("t1_p0_o", {20'b0, pkt_origin}, 0);
        chk("t1_p0_d", {20'b0, pkt_dest}, 3);
        tick();
        chk("t1_p1_d", {20'b0, pkt_dest}, 5);
        tick();
        chk("t1_p2_d", {20'b0, pkt_dest}, 7);
        tick();
        chk("t1_end_vld", {31'b0, pkt_valid}, 0);
        chk("t1_done", {31'b0, done}, 1);
        chk("t1_end_busy", {31'b0, busy}, 1);
        tick();
        chk("t1_idle_busy", {31'b0, busy}, 0);
        chk("t1_idle_done", {31'b0, done}, 0);
        tick();

        // 2: two neurons with one FIND gap
        clear_lists();
        fire(10'b0000000101);
        collect("t2", 40);
        expect_pkt(0, 3); expect_pkt(0, 5); expect_pkt(0, 7);
        expect_pkt(2, 4); expect_pkt(2, 5); expect_pkt(2, 6);
        check_pkts("t2");
        chk("t2_done", n_done, 1);
        if (got_c.size() >= 4) begin
            chk("t2_gap", got_c[3] - got_c[2], 2);
        end
        tick();

        // 3: backpressure on (0,5)
        fire(10'b0000000001);
        tick();
        chk("t3_p0_d", {20'b0, pkt_dest}, 3);
        tick();
        pkt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_hold_v%0d", k), {31'b0, pkt_valid}, 1);
            chk($sformatf("t3_hold_d%0d", k), {20'b0, pkt_dest}, 5);
            tick();
        end
        chk("t3_still_d", {20'b0, pkt_dest}, 5);
        pkt_ready = 1'b1;
        tick();
        chk("t3_p2_d", {20'b0, pkt_dest}, 7);
        tick();
        chk("t3_end_vld", {31'b0, pkt_valid}, 0);
        clear_lists();
        collect("t3", 10);
        tick();

        // 4: second strobe during a scan goes to pending
        clear_lists();
        spike       = 10'b0000000001;
        spike_valid = 1'b1;
        tick();
        spike       = 10'b0000000010;
        tick();
        spike_valid = 1'b0;
        spike       = '0;
        collect("t4", 40);
        expect_pkt(0, 3); expect_pkt(0, 5); expect_pkt(0, 7);
        expect_pkt(1, 4); expect_pkt(1, 6);
        check_pkts("t4");
        chk("t4_done", n_done, 2);
        tick();

        // 5: neuron 2 has end < start
        clear_lists();
        ptr_t[3] = 5'd1;
        fire(10'b0000000100);
        collect("t5", 20);
        check_pkts("t5");
        chk("t5_done", n_done, 1);
        chk("t5_err", {31'b0, cfg_err}, 1);
        load_table();
        tick();
        chk("t5_err_sticky", {31'b0, cfg_err}, 1);

        // 6: asynchronous reset mid-EMIT
        fire(10'b0000000001);
        tick();
        chk("t6_pre_vld", {31'b0, pkt_valid}, 1);
        RESETn = 1'b0;
        #1;
        chk("t6_rst_vld", {31'b0, pkt_valid}, 0);
        chk("t6_rst_busy", {31'b0, busy}, 0);
        chk("t6_rst_dest", {20'b0, pkt_dest}, 0);
        chk("t6_rst_err", {31'b0, cfg_err}, 0);
        tick();
        RESETn = 1'b1;
        tick();
        clear_lists();
        fire(10'b0000000001);
        collect("t6", 20);
        expect_pkt(0, 3); expect_pkt(0, 5); expect_pkt(0, 7);
        check_pkts("t6");
        tick();

        // 7: range ending exactly at capacity, opaque high addresses
        clear_lists();
        ptr_t[9]  = 5'd28;
        ptr_t[10] = 5'd30;
        ent_t[28] = 12'hFFF;
        ent_t[29] = 12'hABC;
        fire(10'b1000000000);
        collect("t7", 20);
        expect_pkt(9, 12'hFFF); expect_pkt(9, 12'hABC);
        check_pkts("t7");
        chk("t7_err", {31'b0, cfg_err}, 0);
        tick();

        // 8: range end beyond capacity is skipped and flagged
        clear_lists();
        ptr_t[10] = 5'd31;
        fire(10'b1000000000);
        collect("t8", 20);
        check_pkts("t8");
        chk("t8_done", n_done, 1);
        chk("t8_err", {31'b0, cfg_err}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
